// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freeze with timeout, post-reset fill, and saturating event counters.

module pipe_hazard_ctrl_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (inc && count != '1)  count <= count + CNT_W'(1);
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int FILL_CYCLES = 4,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IF_ID_instr,
  input  logic [2:0]       ID_EX_mctlout,
  input  logic [4:0]       ID_EX_instrout_2016,
  input  logic             EX_MEM_PCSrc,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int FW = $clog2(FILL_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [FW-1:0] fill_cnt, fill_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic          lu, run_eval, stall_inc, flush_inc;
  logic [1:0]    cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  // Only the memread bit and the rs/rt fields take part in hazard detection.
  logic unused_bits;
  assign unused_bits = ^{IF_ID_instr[31:26], IF_ID_instr[15:0],
                         ID_EX_mctlout[2], ID_EX_mctlout[0]};

  assign lu = ID_EX_mctlout[1] && (ID_EX_instrout_2016 != 5'd0) &&
              ((ID_EX_instrout_2016 == IF_ID_instr[25:21]) ||
               (ID_EX_instrout_2016 == IF_ID_instr[20:16]));

  always_comb begin
    state_nx    = state;
    fill_nx     = fill_cnt;
    wait_nx     = wait_cnt;
    run_eval    = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state)
      S_FILL: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        fill_nx     = fill_cnt + FW'(1);
        if (fill_cnt == FW'(FILL_CYCLES - 1)) state_nx = S_RUN;
      end
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          pipe_freeze = 1'b1;
          state_nx    = S_WAIT;
          wait_nx     = WW'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      S_WAIT: begin
        if (!mem_ready) begin
          pipe_freeze = 1'b1;
          if (wait_cnt == WW'(MAX_WAIT - 1)) state_nx = S_ERR;
          else                               wait_nx  = wait_cnt + WW'(1);
        end else begin
          // The completing cycle also services whatever branch/hazard is pending.
          state_nx = S_RUN;
          run_eval = 1'b1;
        end
      end
      default: pipe_freeze = 1'b1;
    endcase

    if (run_eval) begin
      if (EX_MEM_PCSrc) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (lu) begin
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      fill_cnt    <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      wait_cnt <= wait_nx;
      if (state_nx == S_ERR) mem_timeout <= 1'b1;
    end
  end

  assign cnt_inc = {flush_inc, stall_inc};

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    pipe_hazard_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[g]),
      .count (cnt_q[g])
    );
  end

  assign stall_count = cnt_q[0];
  assign flush_count = cnt_q[1];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations for the fill, stall, freeze, timeout and saturation cases.
module tb_pipe_hazard_ctrl;
  localparam int FILL_CYCLES = 4;
  localparam int MAX_WAIT    = 16;
  localparam int CNT_W       = 4;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      IF_ID_instr;
  logic [2:0]       ID_EX_mctlout;
  logic [4:0]       ID_EX_instrout_2016;
  logic             EX_MEM_PCSrc, mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl #(.FILL_CYCLES(FILL_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .IF_ID_instr(IF_ID_instr), .ID_EX_mctlout(ID_EX_mctlout),
    .ID_EX_instrout_2016(ID_EX_instrout_2016), .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles of fill left, length of the current freeze, dead after timeout.
  int m_fill_left = FILL_CYCLES;
  int m_frozen    = 0;
  bit m_dead      = 1'b0;
  bit m_timeout   = 1'b0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  task automatic model_step();
    bit lu;
    int e_pc, e_ifw, e_iff, e_idf, e_frz;
    if (rst) begin
      m_fill_left = FILL_CYCLES; m_frozen = 0; m_dead = 0;
      m_timeout = 0; m_stalls = 0; m_flushes = 0;
    end
    chk("stall_count", stall_count, (m_stalls > SAT) ? SAT : m_stalls);
    chk("flush_count", flush_count, (m_flushes > SAT) ? SAT : m_flushes);
    chk("mem_timeout", mem_timeout, m_timeout);

    lu = ID_EX_mctlout[1] && ID_EX_instrout_2016 != 0 &&
         (ID_EX_instrout_2016 == IF_ID_instr[25:21] || ID_EX_instrout_2016 == IF_ID_instr[20:16]);
    {e_pc, e_ifw, e_iff, e_idf, e_frz} = '0;
    if (rst || (!m_dead && m_fill_left > 0)) begin
      e_iff = 1; e_idf = 1;
      if (!rst) m_fill_left--;
    end else if (m_dead) begin
      e_frz = 1;
    end else if (!mem_ready && (mem_req || m_frozen > 0)) begin
      e_frz = 1;
      m_frozen++;
      if (m_frozen == MAX_WAIT) begin m_dead = 1; m_timeout = 1; end
    end else begin
      m_frozen = 0;
      if (EX_MEM_PCSrc) begin
        e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; m_flushes++;
      end else if (lu) begin
        e_idf = 1; m_stalls++;
      end else begin
        e_pc = 1; e_ifw = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("if_id_write", if_id_write, e_ifw);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_flush", id_ex_flush, e_idf);
    chk("pipe_freeze", pipe_freeze, e_frz);
  endtask

  always @(negedge clk) begin
    #1;
    model_step();
  end

  task automatic tick(input bit r, input logic [31:0] ins, input logic [2:0] mc,
                      input logic [4:0] rtv, input bit br, input bit mr, input bit rdy);
    @(negedge clk);
    rst = r; IF_ID_instr = ins; ID_EX_mctlout = mc; ID_EX_instrout_2016 = rtv;
    EX_MEM_PCSrc = br; mem_req = mr; mem_ready = rdy;
    #2;
  endtask

  task automatic idle();
    tick(0, 32'd0, 3'b000, 5'd0, 0, 0, 0);
  endtask

  task automatic lu_cycle(input bit br);
    tick(0, 32'd8 << 21, 3'b010, 5'd8, br, 0, 0);
  endtask

  task automatic fill_check(input string name);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      idle();
      if (pc_write) done = 1;
      else begin n++; chk({name, "_if_id_flush"}, if_id_flush, 1); end
    end
    chk(name, n, FILL_CYCLES);
  endtask

  initial begin
    int nf;
    rst = 1; IF_ID_instr = '0; ID_EX_mctlout = '0; ID_EX_instrout_2016 = '0;
    EX_MEM_PCSrc = 0; mem_req = 0; mem_ready = 0;
    tick(1, 32'd0, 3'b000, 5'd0, 0, 0, 0);
    tick(1, 32'd0, 3'b000, 5'd0, 0, 0, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_if_id_flush", if_id_flush, 1);
    chk("rst_timeout", mem_timeout, 0);

    fill_check("fill_len");

    lu_cycle(0);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    idle();
    chk("lu_stall_count", stall_count, 1);

    tick(0, 32'd0, 3'b010, 5'd0, 0, 0, 0);
    chk("rt0_pc_write", pc_write, 1);
    chk("rt0_id_ex_flush", id_ex_flush, 0);

    lu_cycle(1);
    chk("br_lu_if_id_flush", if_id_flush, 1);
    chk("br_lu_pc_write", pc_write, 1);
    idle();
    chk("br_lu_flush_count", flush_count, 1);
    chk("br_lu_stall_count", stall_count, 1);

    nf = 0;
    repeat (3) begin tick(0, 32'd0, 3'b000, 5'd0, 0, 1, 0); nf += int'(pipe_freeze); end
    tick(0, 32'd0, 3'b000, 5'd0, 0, 1, 1);
    chk("freeze_release", pipe_freeze, 0);
    chk("freeze_len", nf, 3);
    idle();
    chk("freeze_back_run", pc_write, 1);

    repeat (2) tick(0, 32'd0, 3'b000, 5'd0, 0, 1, 0);
    tick(0, 32'd0, 3'b000, 5'd0, 1, 1, 1);
    chk("wait_branch_flush", if_id_flush, 1);
    chk("wait_branch_freeze", pipe_freeze, 0);
    idle();
    chk("wait_branch_count", flush_count, 2);

    repeat (20) lu_cycle(0);
    idle();
    chk("stall_saturate", stall_count, SAT);

    nf = 0;
    for (int i = 0; i < 40 && !mem_timeout; i++) begin
      tick(0, 32'd0, 3'b000, 5'd0, 0, 1, 0);
      if (!mem_timeout && pipe_freeze) nf++;
    end
    chk("timeout_seen", mem_timeout, 1);
    chk("timeout_after", nf, MAX_WAIT);
    tick(0, 32'd8 << 21, 3'b010, 5'd8, 1, 0, 1);
    chk("err_sticky", mem_timeout, 1);
    chk("err_freeze", pipe_freeze, 1);
    chk("err_no_flush", if_id_flush, 0);

    tick(1, 32'd0, 3'b000, 5'd0, 0, 0, 0);
    chk("rerst_timeout", mem_timeout, 0);
    chk("rerst_stall_count", stall_count, 0);
    chk("rerst_flush_count", flush_count, 0);
    fill_check("refill_len");

    repeat (2) tick(0, 32'd0, 3'b000, 5'd0, 0, 1, 0);
    tick(1, 32'd0, 3'b000, 5'd0, 0, 1, 0);
    chk("rst_in_wait_freeze", pipe_freeze, 0);
    fill_check("wait_refill_len");
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the PC and pipeline-register enables and flushes for ifetch, IDECODE and the later stages.
- Detects load-use hazards between the ID/EX and IF/ID stages.
- Flushes the pipeline on a taken branch (EX_MEM_PCSrc).
- Freezes the whole pipeline while data memory is busy.
- Holds the pipeline idle for a fill period after reset.
- Keeps saturating performance counters for stalls and flushes.

Parameters:
FILL_CYCLES, 4, cycles the pipeline is held idle after reset release (minimum 1)
MAX_WAIT, 16, maximum MEM_WAIT cycles before a timeout is declared (minimum 2)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
IF_ID_instr  in  32  instruction in IF/ID; rs = [25:21], rt = [20:16]
ID_EX_mctlout  in  3  ID/EX memory control {branch, memread, memwrite}; memread = bit 1
ID_EX_instrout_2016  in  5  rt field held in ID/EX
EX_MEM_PCSrc  in  1  branch taken, resolved in MEM
mem_req  in  1  data-memory access in MEM this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  zero IF/ID on the next edge
id_ex_flush  out  1  zero the ID/EX control fields (bubble) on the next edge
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
mem_timeout  out  1  sticky timeout error flag
stall_count  out  CNT_W  load-use stall cycles, saturating
flush_count  out  CNT_W  branch flushes, saturating

Behaviour:
- State register: FILL, RUN, MEM_WAIT, ERROR. Asynchronous reset puts it in FILL with fill_cnt = 0, wait_cnt = 0 and both counters = 0.
- All control outputs are combinational from (state, inputs). Counters and mem_timeout are registered.
- Load-use hazard, lu = ID_EX_mctlout[1] && ID_EX_instrout_2016 != 0 && (ID_EX_instrout_2016 == IF_ID_instr[25:21] || ID_EX_instrout_2016 == IF_ID_instr[20:16]).
- FILL:
  - Outputs: pc_write = 0, if_id_write = 0, if_id_flush = 1, id_ex_flush = 1, pipe_freeze = 0.
  - fill_cnt increments each cycle. When fill_cnt == FILL_CYCLES-1, go to RUN.
  - Outputs while rst is high equal the FILL values; mem_timeout = 0.
- RUN: evaluate in priority order.
  1. mem_req && !mem_ready:
     - pipe_freeze = 1, pc_write = 0, if_id_write = 0, no flushes.
     - Go to MEM_WAIT with wait_cnt = 1.
  2. EX_MEM_PCSrc:
     - pc_write = 1, if_id_write = 1, if_id_flush = 1, id_ex_flush = 1.
     - flush_count += 1 (saturating). Stay in RUN.
     - lu is ignored this cycle, because the flush removes the dependent instruction.
  3. lu:
     - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
     - stall_count += 1 (saturating). Stay in RUN.
  4. Otherwise: pc_write = 1, if_id_write = 1, every other control output 0.
- MEM_WAIT:
  - While mem_ready = 0: outputs are frozen (as in RUN case 1) and wait_cnt increments.
  - mem_ready = 1: go to RUN. In that same cycle the RUN rules 2-4 apply, so a pending branch or load-use is serviced immediately.
  - wait_cnt == MAX_WAIT-1 with mem_ready still 0: go to ERROR.
- ERROR:
  - Outputs frozen as in MEM_WAIT; mem_timeout = 1.
  - Held until rst; inputs are ignored.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- rst asserted mid-operation (e.g. in MEM_WAIT): immediate return to FILL, counters cleared, mem_timeout cleared.

Test Plan:
- Reset release, FILL_CYCLES = 4, no requests -> pc_write = 0 for exactly 4 cycles after release, then 1; if_id_flush = 1 during those 4 cycles.
- ID_EX_mctlout = 3'b010, ID_EX_instrout_2016 = 5'd8, IF_ID_instr rs = 8 -> one cycle with pc_write = 0, if_id_write = 0, id_ex_flush = 1 and stall_count 0 -> 1. Same stimulus with rt field = 0 -> no stall.
- Load-use condition true and EX_MEM_PCSrc = 1 in the same cycle -> if_id_flush = 1, pc_write = 1, flush_count = 1, stall_count unchanged.
- mem_req = 1 with mem_ready low for 3 cycles, then high -> pipe_freeze = 1 for exactly 3 cycles, deasserted in the mem_ready cycle, state back in RUN.
- MAX_WAIT = 16, mem_req = 1 with mem_ready held low -> mem_timeout rises after the 16th wait cycle and stays 1; asserting rst clears it and returns to FILL.
- CNT_W = 4 with 20 consecutive load-use cycles -> stall_count saturates at 15.
